// File: rtl/nvram_pkg.sv
// Shared definitions for the NVRAM upload responder: FSM states and constants.
package nvram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    OOR
  } state_t;

  localparam logic [7:0] OOR_DATA = 8'hFF;
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/nvram_uploader.sv
// Serves HPS upload reads from the core NVRAM, stretching each with ioctl_wait,
// and flags the buffer dirty until a complete upload session has been served.
module nvram_uploader
  import nvram_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned RAM_LATENCY  = 2,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_dout,
  input  logic              core_wr,
  output logic              save_req,
  output logic              busy
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             upload_q;
  logic             last_done;

  logic sel;
  logic in_range;
  logic upload_fall;
  logic last_hit;

  assign sel         = ioctl_rd & ioctl_upload & (ioctl_index == UPLOAD_INDEX);
  assign in_range    = (ioctl_addr[24:ADDR_W] == '0);
  assign upload_fall = upload_q & ~ioctl_upload;
  assign last_hit    = (state == READ) && (cnt == '0) && (ram_addr == '1);

  // Read FSM; ioctl_rd is only looked at in IDLE, so host strobes during a read are dropped.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ram_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (sel) begin
            ioctl_wait <= 1'b1;
            busy       <= 1'b1;
            if (in_range) begin
              ram_addr <= ioctl_addr[ADDR_W-1:0];
              ram_rd   <= 1'b1;
              cnt      <= CNT_W'(RAM_LATENCY);
              state    <= READ;
            end else begin
              state <= OOR;
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            ioctl_din  <= ram_dout;
            ioctl_wait <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OOR: begin
          ioctl_din  <= OOR_DATA;
          ioctl_wait <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          ioctl_wait <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // A last-address read finishing after the session ended must not arm the next session.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      upload_q  <= 1'b0;
      last_done <= 1'b0;
      save_req  <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      if (upload_fall)
        last_done <= 1'b0;
      else if (last_hit && ioctl_upload)
        last_done <= 1'b1;
      if (core_wr)
        save_req <= 1'b1;
      else if (upload_fall && last_done)
        save_req <= 1'b0;
    end
  end

endmodule
